// File: rtl/sysref_gate_ctrl.sv
// sysref_gate_ctrl
//   Arms on request, measures one reference SYSREF period, then forwards a
//   counted number of SYSREF pulses (0 = unlimited) toward the RF-ADC with
//   one pl_clk cycle of latency. The pulse that closes the measurement is
//   never forwarded. Interval timeout, abort and sync reset return to a
//   safe state with the output low.
//
//   Optional: define SYSREF_PERIOD_CHECK_EN to compare every forwarded
//   interval against the latched period (+/-TOL); a bad interval goes to ERR.
//
// Ports
//   pl_clk      : clock, all logic on rising edge
//   pl_rst      : synchronous active-high reset
//   sysref_in   : SYSREF level already in pl_clk domain
//   arm         : one-cycle request to start a sequence (IDLE/DONE/ERR only)
//   abort       : one-cycle request to return to IDLE (highest priority)
//   num_pulses  : edges to forward, sampled with arm; 0 = unlimited
//   sysref_out  : gated, registered SYSREF
//   busy        : high in ARMED, MEASURE, FORWARD, TAIL
//   done        : high in DONE
//   err         : high in ERR
//   period      : latched reference period in pl_clk cycles
module sysref_gate_ctrl #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned TOL   = 0
) (
   input  logic             pl_clk,
   input  logic             pl_rst,
   input  logic             sysref_in,
   input  logic             arm,
   input  logic             abort,
   input  logic [7:0]       num_pulses,
   output logic             sysref_out,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] period
);

`ifdef SYSREF_PERIOD_CHECK_EN
   localparam bit PERIOD_CHECK = 1'b1;
`else
   localparam bit PERIOD_CHECK = 1'b0;
`endif

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE, ARMED, MEASURE, FORWARD, TAIL, DONE, ERR
   } state_t;

   state_t           state, state_nx;
   logic             sysref_d;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [7:0]       fwd_cnt, fwd_nx, fwd_inc;
   logic [7:0]       num_lat, num_nx;
   logic [CNT_W-1:0] period_nx;
   logic             out_nx;
   logic             rise;
   logic             last_edge;
   logic             period_bad;
   logic [CNT_W:0]   cnt_x, per_x, tol_x;

   assign rise      = sysref_in & ~sysref_d;
   assign fwd_inc   = fwd_cnt + 8'd1;
   assign last_edge = (num_lat != 8'd0) && (fwd_inc == num_lat);

   // One extra bit so period +/- TOL never wraps.
   assign cnt_x = {1'b0, cnt};
   assign per_x = {1'b0, period};
   assign tol_x = (CNT_W+1)'(TOL);
   assign period_bad = PERIOD_CHECK &&
                       ((cnt_x > per_x + tol_x) || (cnt_x + tol_x < per_x));

   assign busy = (state == ARMED) || (state == MEASURE) ||
                 (state == FORWARD) || (state == TAIL);
   assign done = (state == DONE);
   assign err  = (state == ERR);

   always_ff @(posedge pl_clk) begin
      if (pl_rst) begin
         state      <= IDLE;
         sysref_d   <= 1'b0;
         sysref_out <= 1'b0;
         cnt        <= '0;
         fwd_cnt    <= '0;
         num_lat    <= '0;
         period     <= '0;
      end else begin
         state      <= state_nx;
         sysref_d   <= sysref_in;
         sysref_out <= out_nx;
         cnt        <= cnt_nx;
         fwd_cnt    <= fwd_nx;
         num_lat    <= num_nx;
         period     <= period_nx;
      end
   end

   // Output gating: a rise is forwarded only when accepted in FORWARD; the
   // rest of a pulse follows only if its first cycle was forwarded
   // (sysref_out still high), which drops the pulse that ended MEASURE.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      fwd_nx    = fwd_cnt;
      num_nx    = num_lat;
      period_nx = period;
      out_nx    = 1'b0;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE, DONE, ERR: begin
               if (arm) begin
                  state_nx = ARMED;
                  num_nx   = num_pulses;
                  fwd_nx   = '0;
                  cnt_nx   = '0;
               end
            end
            ARMED: begin
               if (rise) begin
                  state_nx = MEASURE;
                  cnt_nx   = CNT_ONE;
               end
            end
            MEASURE: begin
               if (rise) begin
                  period_nx = cnt;
                  cnt_nx    = CNT_ONE;
                  state_nx  = FORWARD;
               end else if (cnt == CNT_MAX) begin
                  state_nx = ERR;
               end else begin
                  cnt_nx = cnt + CNT_ONE;
               end
            end
            FORWARD: begin
               if (rise) begin
                  if (period_bad) begin
                     state_nx = ERR;
                  end else begin
                     fwd_nx = fwd_inc;
                     cnt_nx = CNT_ONE;
                     out_nx = 1'b1;
                     if (last_edge) state_nx = TAIL;
                  end
               end else begin
                  out_nx = sysref_in & sysref_out;
                  if (cnt == CNT_MAX) state_nx = ERR;
                  else                cnt_nx   = cnt + CNT_ONE;
               end
            end
            TAIL: begin
               out_nx = sysref_in & sysref_out;
               if (!sysref_in) state_nx = DONE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sysref_gate_ctrl.sv
module tb_sysref_gate_ctrl;

   logic        pl_clk;
   logic        pl_rst;
   logic        sysref_in;
   logic        arm;
   logic        abort;
   logic [7:0]  num_pulses;
   logic        sysref_out, busy, done, err;
   logic [15:0] period;
   logic        sysref_out_to, busy_to, done_to, err_to;
   logic [3:0]  period_to;

   int n_vec = 0;
   int n_err = 0;

   sysref_gate_ctrl #(.CNT_W(16), .TOL(0)) u_dut (
      .pl_clk(pl_clk), .pl_rst(pl_rst), .sysref_in(sysref_in), .arm(arm),
      .abort(abort), .num_pulses(num_pulses), .sysref_out(sysref_out),
      .busy(busy), .done(done), .err(err), .period(period)
   );

   sysref_gate_ctrl #(.CNT_W(4), .TOL(0)) u_to (
      .pl_clk(pl_clk), .pl_rst(pl_rst), .sysref_in(sysref_in), .arm(arm),
      .abort(abort), .num_pulses(num_pulses), .sysref_out(sysref_out_to),
      .busy(busy_to), .done(done_to), .err(err_to), .period(period_to)
   );

   initial pl_clk = 1'b0;
   always #5 pl_clk = ~pl_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] p(input int r);
      logic [63:0] two_hi;
      two_hi = 64'h3;
      return two_hi << r;
   endfunction

   task automatic tick();
      @(posedge pl_clk);
      #1;
   endtask

   task automatic do_reset();
      pl_rst = 1'b1; sysref_in = 1'b0; arm = 1'b0; abort = 1'b0;
      tick();
      pl_rst = 1'b0;
   endtask

   task automatic do_arm(input string tag, input logic [7:0] num);
      num_pulses = num; arm = 1'b1; sysref_in = 1'b0;
      tick();
      arm = 1'b0;
      check({tag, " busy after arm"}, busy, 1);
   endtask

   // Drives one SYSREF bit per cycle and checks sysref_out every cycle.
   task automatic run_pat(input string tag, input int n,
                          input logic [63:0] in_pat, input logic [63:0] exp_out,
                          input int abort_at, input int arm_at,
                          output int first_done, output int first_err,
                          output int first_err_to, output int out_to_hi);
      first_done = -1; first_err = -1; first_err_to = -1; out_to_hi = 0;
      for (int k = 0; k < n; k++) begin
         sysref_in = in_pat[k];
         abort     = (k == abort_at);
         arm       = (k == arm_at);
         tick();
         check($sformatf("%s out[%0d]", tag, k), sysref_out, exp_out[k]);
         if (done && first_done < 0) first_done = k;
         if (err && first_err < 0) first_err = k;
         if (err_to && first_err_to < 0) first_err_to = k;
         if (sysref_out_to) out_to_hi++;
      end
      abort = 1'b0; arm = 1'b0; sysref_in = 1'b0;
   endtask

   initial begin
      int fd, fe, fe2, oh;
      pl_rst = 1'b1; sysref_in = 1'b0; arm = 1'b0; abort = 1'b0; num_pulses = 8'd0;
      tick(); tick();
      pl_rst = 1'b0;
      check("rst sysref_out", sysref_out, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst err", err, 0);
      check("rst period", period, 0);

      // Nominal: period 8, 2 high, 3 pulses forwarded (rises 16, 24, 32).
      do_arm("nom", 8'd3);
      run_pat("nom", 56, p(0)|p(8)|p(16)|p(24)|p(32)|p(40)|p(48),
              p(16)|p(24)|p(32), -1, -1, fd, fe, fe2, oh);
      check("nom done cycle", fd, 34);
      check("nom err cycle", fe, -1);
      check("nom period", period, 8);
      check("nom done", done, 1);
      check("nom busy", busy, 0);

      // Second forwarded interval is 9 (rise at 25 instead of 24).
      do_arm("pchk", 8'd3);
`ifdef SYSREF_PERIOD_CHECK_EN
      run_pat("pchk", 48, p(0)|p(8)|p(16)|p(25)|p(33)|p(41),
              p(16), -1, -1, fd, fe, fe2, oh);
      check("pchk err cycle", fe, 25);
      check("pchk done cycle", fd, -1);
      check("pchk err", err, 1);
`else
      run_pat("pchk", 48, p(0)|p(8)|p(16)|p(25)|p(33)|p(41),
              p(16)|p(25)|p(33), -1, -1, fd, fe, fe2, oh);
      check("pchk err cycle", fe, -1);
      check("pchk done cycle", fd, 35);
      check("pchk done", done, 1);
`endif
      check("pchk period", period, 8);

      // Timeout on the CNT_W=4 instance: one edge, then silence.
      do_reset();
      check("to rst period", period_to, 0);
      check("to rst err", err_to, 0);
      do_arm("to", 8'd0);
      run_pat("to", 24, p(0), 64'd0, -1, -1, fd, fe, fe2, oh);
      check("to err cycle", fe2, 15);
      check("to out never high", oh, 0);
      check("to err", err_to, 1);
      check("to busy", busy_to, 0);
      check("to wide no err", fe, -1);
      check("to wide busy", busy, 1);

      // Abort on 2nd high cycle of the 5th forwarded pulse, with arm.
      do_reset();
      do_arm("abt", 8'd0);
      run_pat("abt", 56, p(0)|p(8)|p(16)|p(24)|p(32)|p(40)|p(48),
              p(16)|p(24)|p(32)|p(40)|(p(48) & ~p(49)), 49, 49, fd, fe, fe2, oh);
      check("abt busy", busy, 0);
      check("abt done", done, 0);
      check("abt err", err, 0);
      check("abt done cycle", fd, -1);

      // Reset after two forwarded edges, then a single-pulse sequence.
      do_arm("rmid", 8'd0);
      run_pat("rmid", 28, p(0)|p(8)|p(16)|p(24), p(16)|p(24), -1, -1, fd, fe, fe2, oh);
      check("rmid busy before rst", busy, 1);
      do_reset();
      check("rmid rst sysref_out", sysref_out, 0);
      check("rmid rst busy", busy, 0);
      check("rmid rst done", done, 0);
      check("rmid rst err", err, 0);
      check("rmid rst period", period, 0);
      do_arm("one", 8'd1);
      run_pat("one", 32, p(0)|p(8)|p(16)|p(24), p(16), -1, -1, fd, fe, fe2, oh);
      check("one done cycle", fd, 18);
      check("one done", done, 1);
      check("one busy", busy, 0);
      check("one period", period, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sysref_gate_ctrl.md
SYSREF_GATE_CTRL -- requirements
Module: sysref_gate_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the SYSREF period and interval counters.
REQ-002 Parameter TOL, default 0, sets the allowed interval deviation in pl_clk cycles, applied as +/-TOL.
REQ-003 pl_clk  in  1  is the single clock; all logic is on its rising edge.
REQ-004 pl_rst  in  1  is the reset, which is synchronous and active-high.
REQ-005 sysref_in  in  1  is the SYSREF level already captured in the pl_clk domain.
REQ-006 arm  in  1  is a one-cycle request to start a capture sequence.
REQ-007 abort  in  1  is a one-cycle request to return to IDLE.
REQ-008 num_pulses  in  8  is the number of SYSREF edges to forward; it is sampled when arm is accepted, and 0 means unlimited.
REQ-009 sysref_out  out  1  is the gated SYSREF level toward the RF-ADC.
REQ-010 busy  out  1  is high in ARMED, MEASURE, FORWARD and TAIL.
REQ-011 done  out  1  is high in DONE.
REQ-012 err  out  1  is high in ERR.
REQ-013 period  out  CNT_W  is the latched reference SYSREF period in pl_clk cycles.

Function
REQ-014 Edge detection SHALL use a registered copy sysref_d: rise = sysref_in & ~sysref_d.
REQ-015 The FSM SHALL have the states IDLE, ARMED, MEASURE, FORWARD, TAIL, DONE and ERR.
REQ-016 IDLE/DONE/ERR SHALL accept arm: go to ARMED, latch num_pulses, and clear the forwarded-edge count.
- arm is ignored in all other states.
REQ-017 ARMED SHALL go to MEASURE on rise and set the interval counter to 1.
REQ-018 MEASURE: counter increments by 1 per cycle.
- On rise: latch period = counter, reset counter to 1, go to FORWARD.
- This edge is not forwarded.
REQ-019 If the counter reaches all-ones in MEASURE or FORWARD without a rise, the FSM SHALL go to ERR (timeout), with no wrap-around.
REQ-020 FORWARD: each rise increments the forwarded-edge count and resets the counter to 1.
REQ-021 FORWARD, last edge: when num_pulses != 0 and the count reaches num_pulses on a rise, the FSM SHALL go to TAIL.
REQ-022 TAIL SHALL go to DONE on the first cycle where sysref_in == 0.
REQ-023 sysref_out SHALL be registered: sysref_out <= sysref_in while in FORWARD or TAIL, else 0.
- Latency is 1 cycle.
- The pulse that ends MEASURE is excluded.
REQ-024 abort SHALL force IDLE on the next edge from any state and force sysref_out to 0 on that same edge.
- abort has priority over arm, rise and timeout in the same cycle.
REQ-025 When timeout and rise occur in the same cycle, rise SHALL win.
REQ-026 The counter SHALL saturate at all-ones.
- Any comparison against period SHALL be done at CNT_W+1 bits, so that period +/- TOL cannot wrap.

Reset
REQ-027 pl_rst SHALL set: state = IDLE, sysref_d = 0, sysref_out = 0, busy = 0, done = 0, err = 0, period = 0, counters = 0.
REQ-028 pl_rst mid-sequence SHALL abandon the sequence, and the next accepted arm SHALL restart it from ARMED.

Configuration
REQ-029 With macro SYSREF_PERIOD_CHECK_EN defined, each FORWARD rise SHALL compare counter with period.
- |counter - period| > TOL SHALL go to ERR instead of counting the edge.
- sysref_out is 0 from the next cycle.
REQ-030 Without SYSREF_PERIOD_CHECK_EN, no interval comparison SHALL be made in FORWARD.
- Timeout (REQ-019) still applies.
- period still latches.

Verification
REQ-031 Nominal: SYSREF period 8, high 2 cycles; arm with num_pulses = 3.
- Response: period = 8; exactly 3 forwarded pulses, each delayed 1 cycle; done = 1 after the third pulse falls; busy = 0.
REQ-032 Period check (macro defined, TOL = 0): period 8, with the 2nd FORWARD interval = 9.
- Response: err = 1 on the cycle after that rise; that pulse is not forwarded.
- Repeat without the macro: no err, done reached.
REQ-033 Timeout: CNT_W = 4; arm, one SYSREF edge, then none.
- Response: ERR after the counter saturates at 15; sysref_out stays 0 throughout.
REQ-034 Abort mid-pulse: num_pulses = 0, period 8; assert abort during the high phase of the 5th forwarded pulse.
- Response: sysref_out = 0 and state IDLE on the next edge.
- A same-cycle arm is ignored.
REQ-035 Reset mid-FORWARD: assert pl_rst for 1 cycle after 2 forwarded edges.
- Response: all outputs at reset values.
- A subsequent arm with num_pulses = 1 yields one pulse and done.
